// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between the instruction fetch port (i)
// and the load/store port (d). At most one access is granted per cycle, and the
// grant is combinational from the requests. The data port wins conflicts unless
// fetch has been blocked for STARVE_MAX consecutive cycles. Read responses are
// steered back to their issuing port by a MEM_LAT-deep {valid, owner} pipeline.
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..4), STARVE_MAX (1..15)
// Ports:
//   clk, rst (async, active-high)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata          fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   load/store port
//   sram_en/sram_wen/sram_addr/sram_wdata -> SRAM, sram_rdata <- SRAM
//   perf_i_gnt/perf_d_gnt/perf_forced   only when ARB_PERF_CNT_EN is defined
// Optional feature macro: ARB_PERF_CNT_EN (grant/forced-grant counters).
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_i_gnt,
  output logic [31:0]       perf_d_gnt,
  output logic [31:0]       perf_forced
`endif
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] own_q, own_d;   // 1 = response belongs to the d port
  logic               starved_c;
  logic               rd_push_c;

  // Grant selection; all grants are held low while rst is asserted
  always_comb begin
    starved_c = (starve_q == CNT_W'(STARVE_MAX));
    i_gnt     = !rst && i_req && (!d_req || starved_c);
    d_gnt     = !rst && d_req && !(i_req && starved_c);
  end

  // SRAM drive from the winning port; idle bus is all zeros
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = i_addr;
    end
  end

  // Next-state: starvation counter and response pipeline shift
  always_comb begin
    starve_d  = '0;
    rd_push_c = i_gnt || (d_gnt && (d_we == 4'h0));
    vld_d     = '0;
    own_d     = '0;
    if (i_req && !i_gnt) begin
      starve_d = starved_c ? starve_q : starve_q + CNT_W'(1);
    end
    vld_d[0] = rd_push_c;
    own_d[0] = d_gnt;
    for (int unsigned k = 1; k < MEM_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      own_d[k] = own_q[k-1];
    end
  end

  // Asynchronous reset discards any in-flight responses immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
    end
  end

  assign i_rvalid = vld_q[MEM_LAT-1] && !own_q[MEM_LAT-1];
  assign d_rvalid = vld_q[MEM_LAT-1] &&  own_q[MEM_LAT-1];
  assign i_rdata  = rst ? '0 : sram_rdata;
  assign d_rdata  = rst ? '0 : sram_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_d_q, perf_f_q;

  // Wrapping grant counters; a forced grant is an i grant taken against a d request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_f_q <= '0;
    end else begin
      if (i_gnt)                         perf_i_q <= perf_i_q + 32'(1);
      if (d_gnt)                         perf_d_q <= perf_d_q + 32'(1);
      if (i_gnt && d_req && starved_c)   perf_f_q <= perf_f_q + 32'(1);
    end
  end

  assign perf_i_gnt  = perf_i_q;
  assign perf_d_gnt  = perf_d_q;
  assign perf_forced = perf_f_q;
`endif

endmodule
